// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Brief    : Shared FSM encoding and default timing for the switch debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam int STATE_W                 = 2;
    localparam int DEBOUNCE_10MS_AT_100MHZ = 1000000;

    typedef enum logic [STATE_W-1:0] {
        LOW_STABLE  = 2'd0,
        LOW_TO_HIGH = 2'd1,
        HIGH_STABLE = 2'd2,
        HIGH_TO_LOW = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer_if
// Brief    : Raw switch input and conditioned outputs of one debouncer.
// Revision : 1.0 - initial release
// ============================================================================
interface switch_debouncer_if #(
    parameter int PRESS_W = 8
);
    logic               raw_in;
    logic               level;
    logic               rise;
    logic               fall;
    logic [PRESS_W-1:0] press_count;
    logic               settling;

    modport master (
        output raw_in,
        input  level, rise, fall, press_count, settling
    );

    modport slave (
        input  raw_in,
        output level, rise, fall, press_count, settling
    );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchroniser for a single asynchronous bit.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);
    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;
endmodule
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : switch_debouncer
// Brief    : Synchronise and debounce one mechanical switch; level, edges, count.
// Revision : 1.0 - initial release
// ============================================================================
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_10MS_AT_100MHZ,
    parameter int CNT_W         = 20,
    parameter int PRESS_W       = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    switch_debouncer_if.slave bus
);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic               w_s2;
    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_level, w_level_nxt;
    logic               r_rise, w_rise_nxt;
    logic               r_fall, w_fall_nxt;
    logic               r_settling, w_settling_nxt;
    logic [PRESS_W-1:0] r_press, w_press_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.raw_in),
        .o_q (w_s2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LOW_STABLE;
            r_cnt      <= '0;
            r_level    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_settling <= 1'b0;
            r_press    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_level    <= w_level_nxt;
            r_rise     <= w_rise_nxt;
            r_fall     <= w_fall_nxt;
            r_settling <= w_settling_nxt;
            r_press    <= w_press_nxt;
        end
    end

    // Any opposite sample while qualifying drops back to the stable state with no credit kept.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_press_nxt = r_press;
        case (r_state)
            LOW_STABLE: begin
                if (w_s2) begin
                    w_state_nxt = LOW_TO_HIGH;
                    w_cnt_nxt   = c_cnt_one;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            LOW_TO_HIGH: begin
                if (!w_s2) begin
                    w_state_nxt = LOW_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = HIGH_STABLE;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                    w_press_nxt = r_press + PRESS_W'(1);
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            HIGH_STABLE: begin
                if (!w_s2) begin
                    w_state_nxt = HIGH_TO_LOW;
                    w_cnt_nxt   = c_cnt_one;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            HIGH_TO_LOW: begin
                if (w_s2) begin
                    w_state_nxt = HIGH_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = LOW_STABLE;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = LOW_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_settling_nxt = (w_state_nxt == LOW_TO_HIGH) || (w_state_nxt == HIGH_TO_LOW);
    end

    assign bus.level       = r_level;
    assign bus.rise        = r_rise;
    assign bus.fall        = r_fall;
    assign bus.settling    = r_settling;
    assign bus.press_count = r_press;
endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debouncer
// Brief    : Self-checking bench: run-length reference model plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;
    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    switch_debouncer_if #(.PRESS_W(8)) bus ();

    switch_debouncer #(
        .STABLE_CYCLES (STABLE),
        .CNT_W         (3),
        .PRESS_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: count consecutive synchronised samples that disagree with the level.
    logic       m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    logic [7:0] m_press = 8'd0;
    int         m_run = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_level <= 1'b0;
            m_rise <= 1'b0; m_fall <= 1'b0; m_press <= 8'd0; m_run <= 0;
        end else begin
            m_s1   <= bus.raw_in;
            m_s2   <= m_s1;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (m_s2 != m_level) begin
                if (m_run + 1 == STABLE) begin
                    m_level <= m_s2;
                    m_run   <= 0;
                    if (m_s2) begin
                        m_rise  <= 1'b1;
                        m_press <= m_press + 8'd1;
                    end else begin
                        m_fall  <= 1'b1;
                    end
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            logic [11:0] act, exp_v;
            act   = {bus.level, bus.rise, bus.fall, bus.settling, bus.press_count};
            exp_v = {m_level, m_rise, m_fall, (m_run != 0), m_press};
            n_checks++;
            if (act !== exp_v) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t actual=%03h expected=%03h (lvl,rise,fall,settling,press)",
                         $time, act, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_hold(input logic v, input int n);
        @(negedge clk);
        bus.raw_in = v;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        bus.raw_in = 1'b0;
        edges(3);
        check("reset_level", 32'(bus.level), 0);
        check("reset_settling", 32'(bus.settling), 0);
        check("reset_press", 32'(bus.press_count), 0);
        @(negedge clk); rst = 1'b1;
        edges(4);

        // Clean press
        @(negedge clk); bus.raw_in = 1'b1;
        edges(2);
        check("press_settle_E2", 32'(bus.settling), 0);
        edges(1);
        check("press_settle_E3", 32'(bus.settling), 1);
        edges(2);
        check("press_level_E5", 32'(bus.level), 0);
        edges(1);
        check("press_level_E6", 32'(bus.level), 1);
        check("press_rise_E6", 32'(bus.rise), 1);
        check("press_count_E6", 32'(bus.press_count), 1);
        edges(1);
        check("press_rise_E7", 32'(bus.rise), 0);
        check("press_settle_E7", 32'(bus.settling), 0);
        edges(3);

        // Release
        @(negedge clk); bus.raw_in = 1'b0;
        edges(5);
        check("rel_fall_E5", 32'(bus.fall), 0);
        edges(1);
        check("rel_fall_E6", 32'(bus.fall), 1);
        check("rel_level_E6", 32'(bus.level), 0);
        check("rel_press_E6", 32'(bus.press_count), 1);
        edges(1);
        check("rel_fall_E7", 32'(bus.fall), 0);

        // Short glitch of 3 cycles
        drive_hold(1'b1, 3);
        drive_hold(1'b0, 10);
        #1;
        check("glitch_level", 32'(bus.level), 0);
        check("glitch_press", 32'(bus.press_count), 1);
        check("glitch_settling", 32'(bus.settling), 0);

        // Bounce: 1,1,0 then 1 held; rise lands on the 6th edge after the last 0->1
        drive_hold(1'b1, 2);
        drive_hold(1'b0, 1);
        @(negedge clk); bus.raw_in = 1'b1;
        edges(5);
        check("bounce_level_5", 32'(bus.level), 0);
        edges(1);
        check("bounce_level_6", 32'(bus.level), 1);
        check("bounce_rise_6", 32'(bus.rise), 1);
        check("bounce_press_6", 32'(bus.press_count), 2);
        drive_hold(1'b0, 12);

        // Randomised bouncing input against the model
        for (int i = 0; i < 400; i++)
            drive_hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));

        // Async reset mid-settle
        drive_hold(1'b0, 12);
        drive_hold(1'b1, 8);
        drive_hold(1'b0, 12);
        @(negedge clk); bus.raw_in = 1'b1;
        edges(4);
        check("pre_rst_settling", 32'(bus.settling), 1);
        #2 rst = 1'b0;
        #1;
        check("async_settling", 32'(bus.settling), 0);
        check("async_press", 32'(bus.press_count), 0);
        check("async_level", 32'(bus.level), 0);
        @(negedge clk); rst = 1'b1;
        edges(5);
        check("post_rst_level_5", 32'(bus.level), 0);
        edges(1);
        check("post_rst_rise_6", 32'(bus.rise), 1);
        check("post_rst_press_6", 32'(bus.press_count), 1);

        // Wrap: fresh reset then 256 press/release pairs
        @(negedge clk); rst = 1'b0; bus.raw_in = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            drive_hold(1'b1, 8);
            #1;
            check("wrap_press", 32'(bus.press_count), 32'(i % 256));
            drive_hold(1'b0, 8);
        end
        #1;
        check("wrap_final", 32'(bus.press_count), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions one raw mechanical slide-switch or push-button input before it reaches the counter's `switch` input.
- Synchronises the raw input into `clk`, then filters out contact bounce with a stable-time counter and a 4-state FSM.
- Produces three outputs: a clean level, single-cycle rise/fall pulses, and a wrapping count of debounced presses.
- One instance per board input; runs on the 100 MHz board clock, not on a divided clock.

Parameters:
- STABLE_CYCLES, 1000000: consecutive identical synchronised samples needed to accept a new level (10 ms at 100 MHz). Must be >= 2.
- CNT_W, 20: width of the stable-time counter. Must satisfy 2^CNT_W > STABLE_CYCLES.
- PRESS_W, 8: width of press_count.

Ports:
- clk  input  1  board clock, all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- raw_in  input  1  raw switch/button pin, asynchronous to clk, may bounce
- level  output  1  debounced level
- rise  output  1  one-cycle pulse when level goes 0->1
- fall  output  1  one-cycle pulse when level goes 1->0
- press_count  output  PRESS_W  number of accepted 0->1 transitions since reset, wraps
- settling  output  1  high while the FSM is qualifying a candidate change

Behaviour:
- Reset (rst=0, asynchronous): both synchroniser flops, level, rise, fall, press_count, settling and the stable counter are cleared to 0; FSM enters LOW_STABLE.
- Reset mid-settle discards the candidate change completely.
- After rst deasserts with raw_in held at 1, the block qualifies the 1 normally: one rise pulse, and press_count becomes 1.
- Synchroniser: 2 flops (s1 <= raw_in; s2 <= s1). The FSM sees only s2.
- FSM states: LOW_STABLE, LOW_TO_HIGH, HIGH_STABLE, HIGH_TO_LOW.
- LOW_STABLE:
  - s2=1: go to LOW_TO_HIGH, cnt <= 1.
  - s2=0: stay.
- LOW_TO_HIGH:
  - s2=0: bounce, return to LOW_STABLE, cnt <= 0, no output change.
  - s2=1 and cnt == STABLE_CYCLES-1: go to HIGH_STABLE, level <= 1, rise <= 1, press_count <= press_count+1, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- HIGH_STABLE / HIGH_TO_LOW: mirror image of the two states above. The accepting transition sets level <= 0 and fall <= 1. press_count is unchanged.
- rise and fall are registered and high for exactly one cycle. They are never high in the same cycle. They default to 0 in every other cycle.
- settling = 1 exactly while the state is LOW_TO_HIGH or HIGH_TO_LOW (registered, same timing as the state).
- Latency: raw_in changes before edge E1 and then holds. s2 changes at E2. The first qualifying sample is at E3. level/rise/fall update at edge E(STABLE_CYCLES+2).
- Bounce rule: any opposite-value sample during settling restarts qualification from zero. No partial credit, no hysteresis beyond this.
- A pulse on raw_in shorter than STABLE_CYCLES samples never changes level.
- press_count wraps from 2^PRESS_W-1 to 0 on the next accepted rise, with no saturation and no flag.
- cnt never exceeds STABLE_CYCLES-1 and is 0 in both stable states.

Decomposition:
- Shared package `debounce_pkg`:
  - State enum (2-bit, encoding LOW_STABLE=0, LOW_TO_HIGH=1, HIGH_STABLE=2, HIGH_TO_LOW=3)
  - STATE_W=2
  - Default DEBOUNCE_10MS_AT_100MHZ=1000000
- Sub-module `sync_2ff`: 1-bit 2-flop synchroniser with the same clk/rst (async active-low, clears to 0).
- FSM, stable counter and press counter live in switch_debouncer itself.

Test Plan (STABLE_CYCLES=4, PRESS_W=8 unless noted):
- Clean press: raw_in 0->1 before E1, held -> settling=1 from E3 to E5; level=1 and rise=1 at E6 only; press_count=1; fall stays 0.
- Bounce reject: raw_in = 1 for 2 cycles, then 0 for 1 cycle, then 1 held -> level rises exactly 6 edges after the last 0->1 transition; exactly one rise pulse; press_count=1.
- Short glitch: 3-cycle high pulse on raw_in from idle -> level, rise and press_count stay 0; settling returns to 0 after the pulse.
- Release: from level=1, raw_in 1->0 held -> fall=1 for one cycle at E6, level=0, press_count unchanged, rise=0 throughout.
- Wrap: 256 clean press/release pairs -> press_count reads 255 after the 255th press and 0 after the 256th.
- Async reset mid-settle: assert rst=0 between clock edges while in LOW_TO_HIGH -> all outputs 0 immediately, without waiting for a clock edge. Release rst with raw_in held 1 -> rise at the 6th edge after release, press_count=1.
